// File: rtl/adsr_pkg.sv
// Shared state encoding and accumulator constants for the ADSR envelope slice.
package adsr_pkg;

    localparam int unsigned ST_W          = 3;
    localparam int unsigned ACC_W_DEFAULT = 16;
    localparam logic [ACC_W_DEFAULT-1:0] ACC_MAX = '1;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_envelope_if.sv
// Control/shape inputs and envelope outputs of adsr_envelope, grouped as one bus.
interface adsr_envelope_if;
    import adsr_pkg::*;

    logic            enable;
    logic            gate;
    logic [7:0]      attack_rate;
    logic [7:0]      decay_rate;
    logic [7:0]      sustain_level;
    logic [7:0]      release_rate;
    logic [7:0]      env_out;
    logic [ST_W-1:0] env_state;
    logic            env_active;

    modport master (
        output enable, gate, attack_rate, decay_rate, sustain_level, release_rate,
        input  env_out, env_state, env_active
    );

    modport slave (
        input  enable, gate, attack_rate, decay_rate, sustain_level, release_rate,
        output env_out, env_state, env_active
    );

endinterface

// File: rtl/adsr_tick_gen.sv
// Envelope tick prescaler: one-cycle tick every PRESCALE enabled clocks.
module adsr_tick_gen #(
    parameter int unsigned PRESCALE = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    always_comb tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven FSM stepping a saturating accumulator on prescaled ticks.
// Build option: define ADSR_EXP_RELEASE_EN for an exponential release tail.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int unsigned PRESCALE = 256,
    parameter int unsigned ACC_W    = ACC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    adsr_envelope_if.slave  bus
);

    localparam logic [ACC_W-1:0] ACC_TOP   = '1;
    localparam logic [ACC_W:0]   ACC_LIMIT = {1'b0, ACC_TOP};
    localparam logic [ACC_W:0]   ONE       = (ACC_W+1)'(1);

    adsr_state_t      state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, target;
    logic [ACC_W:0]   sum, diff_dec, diff_rel, rel_step;
    logic             gate_d, rise, tick;
    logic [7:0]       env_out_nxt;
    logic [ST_W-1:0]  env_state_nxt;
    logic             env_active_nxt;

    adsr_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (bus.enable),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            acc            <= '0;
            gate_d         <= 1'b0;
            bus.env_out    <= '0;
            bus.env_state  <= '0;
            bus.env_active <= 1'b0;
        end else begin
            state          <= state_nxt;
            acc            <= acc_nxt;
            if (bus.enable) gate_d <= bus.gate;
            bus.env_out    <= env_out_nxt;
            bus.env_state  <= env_state_nxt;
            bus.env_active <= env_active_nxt;
        end
    end

    always_comb begin
        rise     = bus.gate & ~gate_d;
        target   = {bus.sustain_level, {(ACC_W-8){1'b0}}};
        sum      = {1'b0, acc} + {{(ACC_W-7){1'b0}}, bus.attack_rate} + ONE;
        diff_dec = {1'b0, acc} - {{(ACC_W-7){1'b0}}, bus.decay_rate} - ONE;
`ifdef ADSR_EXP_RELEASE_EN
        rel_step = ({1'b0, acc} >> (4'd3 + {1'b0, ~bus.release_rate[7:5]})) + ONE;
`else
        rel_step = {{(ACC_W-7){1'b0}}, bus.release_rate} + ONE;
`endif
        diff_rel  = {1'b0, acc} - rel_step;
        state_nxt = state;
        acc_nxt   = acc;
        // Gate events take the cycle outright: a coinciding tick is consumed without a step.
        if (bus.enable) begin
            if (rise) begin
                state_nxt = ST_ATTACK;
            end else if (!bus.gate && (state == ST_ATTACK || state == ST_DECAY ||
                                       state == ST_SUSTAIN)) begin
                state_nxt = ST_RELEASE;
            end else if (tick) begin
                case (state)
                    ST_ATTACK: begin
                        if (sum >= ACC_LIMIT) begin
                            acc_nxt   = ACC_TOP;
                            state_nxt = ST_DECAY;
                        end else begin
                            acc_nxt = sum[ACC_W-1:0];
                        end
                    end
                    ST_DECAY: begin
                        if (diff_dec[ACC_W] || diff_dec[ACC_W-1:0] <= target) begin
                            acc_nxt   = target;
                            state_nxt = ST_SUSTAIN;
                        end else begin
                            acc_nxt = diff_dec[ACC_W-1:0];
                        end
                    end
                    ST_SUSTAIN: acc_nxt = target;
                    ST_RELEASE: begin
                        if (diff_rel[ACC_W] || diff_rel[ACC_W-1:0] == '0) begin
                            acc_nxt   = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            acc_nxt = diff_rel[ACC_W-1:0];
                        end
                    end
                    default: begin
                        acc_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        env_out_nxt    = acc[ACC_W-1 -: 8];
        env_state_nxt  = state;
        env_active_nxt = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope against a cycle-level behavioural envelope model.
module tb_adsr_envelope;

    localparam int P = 4;
    localparam int M_IDLE = 0, M_ATTACK = 1, M_DECAY = 2, M_SUSTAIN = 3, M_RELEASE = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adsr_envelope_if bus ();

    adsr_envelope #(.PRESCALE(P), .ACC_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int m_st, m_acc, m_pc;
    bit m_gd;
    logic [7:0] e_out;
    logic [2:0] e_st;
    logic       e_act;
    int n_checks = 0;
    int n_pass   = 0;

    // Envelope rules applied to one enabled clock edge, on plain integers.
    function automatic void model_update();
        bit tick, rise;
        int tgt, step;
        if (!bus.enable) return;
        tick = (m_pc == P - 1);
        m_pc = tick ? 0 : m_pc + 1;
        rise = bus.gate && !m_gd;
        m_gd = bus.gate;
        tgt  = int'(bus.sustain_level) * 256;
        if (rise) m_st = M_ATTACK;
        else if (!bus.gate && m_st >= M_ATTACK && m_st <= M_SUSTAIN) m_st = M_RELEASE;
        else if (tick) begin
            case (m_st)
                M_ATTACK: begin
                    m_acc = m_acc + int'(bus.attack_rate) + 1;
                    if (m_acc >= 65535) begin m_acc = 65535; m_st = M_DECAY; end
                end
                M_DECAY: begin
                    m_acc = m_acc - int'(bus.decay_rate) - 1;
                    if (m_acc <= tgt) begin m_acc = tgt; m_st = M_SUSTAIN; end
                end
                M_SUSTAIN: m_acc = tgt;
                M_RELEASE: begin
`ifdef ADSR_EXP_RELEASE_EN
                    step = (m_acc >> (3 + (7 - int'(bus.release_rate[7:5])))) + 1;
`else
                    step = int'(bus.release_rate) + 1;
`endif
                    m_acc = m_acc - step;
                    if (m_acc <= 0) begin m_acc = 0; m_st = M_IDLE; end
                end
                default: m_acc = 0;
            endcase
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) begin
            m_st = 0; m_acc = 0; m_pc = 0; m_gd = 0;
            e_out = '0; e_st = '0; e_act = 1'b0;
        end else begin
            e_out = 8'(m_acc >> 8);
            e_st  = 3'(m_st);
            e_act = (m_st != M_IDLE);
            model_update();
        end
        #1;
    endtask

    task automatic set_rates(input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] s, input logic [7:0] r);
        bus.attack_rate = a; bus.decay_rate = d; bus.sustain_level = s; bus.release_rate = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.gate = 1'b1; bus.enable = 1'b1;
        set_rates(8'hFF, 8'hFF, 8'h80, 8'hFF);
        repeat (3) cyc();
        n_checks++;
        if (bus.env_out !== 8'h00 || bus.env_state !== 3'd0 || bus.env_active !== 1'b0)
            $display("FAIL reset_values: out=%h state=%0d active=%0b required 00/0/0",
                     bus.env_out, bus.env_state, bus.env_active);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (bus.env_out !== e_out || bus.env_state !== e_st || bus.env_active !== e_act)
                $display("FAIL reset_exit cyc%0d: out=%h/%h state=%0d/%0d active=%0b/%0b",
                         i, bus.env_out, e_out, bus.env_state, e_st, bus.env_active, e_act);
            else n_pass++;
        end
        n_checks++;
        if (bus.env_state !== 3'd1)
            $display("FAIL reset_first_rise: state=%0d required 1", bus.env_state);
        else n_pass++;
    endtask

    task automatic test_full_cycle();
        int  peak = 0, n_rel = 0;
        bit  done = 0;
        rst_n = 1'b0; bus.gate = 1'b0; bus.enable = 1'b1;
        set_rates(8'hFF, 8'hFF, 8'h80, 8'hFF);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        bus.gate = 1'b1;
        for (int i = 0; i < 4000 && !done; i++) begin
            cyc();
            n_checks++;
            if (bus.env_out !== e_out || bus.env_state !== e_st || bus.env_active !== e_act)
                $display("FAIL full_attack_decay: out=%h/%h state=%0d/%0d active=%0b/%0b",
                         bus.env_out, e_out, bus.env_state, e_st, bus.env_active, e_act);
            else n_pass++;
            if (int'(bus.env_out) > peak) peak = int'(bus.env_out);
            if (e_st == 3'd3) done = 1;
        end
        n_checks++;
        if (!done) $display("FAIL full_sustain_budget: sustain not reached in 4000 cycles");
        else n_pass++;
        n_checks++;
        if (peak != 255) $display("FAIL full_peak: peak=%h required ff", peak);
        else n_pass++;
        repeat (20) cyc();
        n_checks++;
        if (bus.env_out !== 8'h80 || bus.env_state !== 3'd3)
            $display("FAIL full_sustain: out=%h state=%0d required 80/3", bus.env_out, bus.env_state);
        else n_pass++;
        bus.gate = 1'b0;
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            cyc();
            n_rel++;
            n_checks++;
            if (bus.env_out !== e_out || bus.env_state !== e_st || bus.env_active !== e_act)
                $display("FAIL full_release: out=%h/%h state=%0d/%0d active=%0b/%0b",
                         bus.env_out, e_out, bus.env_state, e_st, bus.env_active, e_act);
            else n_pass++;
            if (bus.env_state === 3'd0) done = 1;
        end
        n_checks++;
        if (!done || n_rel < 128 * P - 1 || n_rel > 128 * P + P + 2 || bus.env_out !== 8'h00)
            $display("FAIL full_release_time: cycles=%0d out=%h required %0d..%0d and 00",
                     n_rel, bus.env_out, 128 * P - 1, 128 * P + P + 2);
        else n_pass++;
    endtask

    task automatic test_retrigger();
        bit done = 0;
        int low = 255;
        set_rates(8'hFF, 8'hFF, 8'h80, 8'h0F);
        bus.gate = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            cyc();
            if (e_out >= 8'h60) done = 1;
        end
        bus.gate = 1'b0;
        done = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            cyc();
            n_checks++;
            if (bus.env_out !== e_out || bus.env_state !== e_st || bus.env_active !== e_act)
                $display("FAIL retrig_release: out=%h/%h state=%0d/%0d", bus.env_out, e_out,
                         bus.env_state, e_st);
            else n_pass++;
            if (e_out <= 8'h40 && e_st == 3'd4) done = 1;
        end
        n_checks++;
        if (!done) $display("FAIL retrig_budget: level 40 not reached in release");
        else n_pass++;
        bus.gate = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            n_checks++;
            if (bus.env_out !== e_out || bus.env_state !== e_st || bus.env_active !== e_act)
                $display("FAIL retrig_attack: out=%h/%h state=%0d/%0d", bus.env_out, e_out,
                         bus.env_state, e_st);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (bus.env_state !== 3'd1)
                    $display("FAIL retrig_state: state=%0d required 1", bus.env_state);
                else n_pass++;
            end
            if (int'(bus.env_out) < low) low = int'(bus.env_out);
        end
        n_checks++;
        if (low < 8'h40) $display("FAIL retrig_no_drop: min out=%h required >= 40", low);
        else n_pass++;
    endtask

    task automatic test_rise_on_tick();
        bit found = 0;
        logic [7:0] lvl;
        bus.gate = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 2 * P && !found; i++) begin
            if (m_pc == P - 1) found = 1;
            else cyc();
        end
        n_checks++;
        if (!found) $display("FAIL tick_align: no tick seen within %0d cycles", 2 * P);
        else n_pass++;
        lvl = 8'(m_acc >> 8);
        bus.gate = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (bus.env_out !== lvl || bus.env_state !== 3'd1)
            $display("FAIL rise_on_tick: out=%h state=%0d required %h/1", bus.env_out,
                     bus.env_state, lvl);
        else n_pass++;
    endtask

    task automatic test_enable_freeze();
        logic [7:0] f_out;
        logic [2:0] f_st;
        repeat (10) cyc();
        bus.enable = 1'b0;
        cyc();
        cyc();
        f_out = e_out;
        f_st  = e_st;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n_checks++;
            if (bus.env_out !== e_out || bus.env_state !== e_st || bus.env_active !== e_act)
                $display("FAIL freeze_hold: out=%h/%h state=%0d/%0d", bus.env_out, e_out,
                         bus.env_state, e_st);
            else n_pass++;
        end
        n_checks++;
        if (bus.env_out !== f_out || bus.env_state !== f_st)
            $display("FAIL freeze_value: out=%h state=%0d required %h/%0d", bus.env_out,
                     bus.env_state, f_out, f_st);
        else n_pass++;
        bus.enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc();
            n_checks++;
            if (bus.env_out !== e_out || bus.env_state !== e_st || bus.env_active !== e_act)
                $display("FAIL freeze_resume: out=%h/%h state=%0d/%0d", bus.env_out, e_out,
                         bus.env_state, e_st);
            else n_pass++;
        end
    endtask

    task automatic test_release_floor();
        bit done = 0, mono = 1;
        logic [7:0] prev;
        bus.gate = 1'b0;
        for (int i = 0; i < 3000 && e_st != 3'd0; i++) cyc();
`ifdef ADSR_EXP_RELEASE_EN
        set_rates(8'hFF, 8'hFF, 8'hC0, 8'hE0);
`else
        set_rates(8'hFF, 8'hFF, 8'h01, 8'hC7);
`endif
        bus.gate = 1'b1;
        for (int i = 0; i < 4000 && !done; i++) begin
            cyc();
            if (e_st == 3'd3) done = 1;
        end
        repeat (4) cyc();
        bus.gate = 1'b0;
        done = 0;
        prev = bus.env_out;
        for (int i = 0; i < 3000 && !done; i++) begin
            cyc();
            n_checks++;
            if (bus.env_out !== e_out || bus.env_state !== e_st || bus.env_active !== e_act)
                $display("FAIL floor_release: out=%h/%h state=%0d/%0d", bus.env_out, e_out,
                         bus.env_state, e_st);
            else n_pass++;
            if (bus.env_out > prev) mono = 0;
            prev = bus.env_out;
            if (bus.env_state === 3'd0) done = 1;
        end
        n_checks++;
        if (!done || !mono || bus.env_out !== 8'h00 || bus.env_active !== 1'b0)
            $display("FAIL floor_idle: done=%0b monotonic=%0b out=%h required 1/1/00", done,
                     mono, bus.env_out);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(199) == 0) bus.gate = ~bus.gate;
            if ($urandom_range(49) == 0) bus.enable = ~bus.enable;
            if (!bus.enable && $urandom_range(9) == 0) bus.enable = 1'b1;
            if ($urandom_range(299) == 0)
                set_rates(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(999) == 0) bus.sustain_level = 8'($urandom_range(1) * 255);
            cyc();
            n_checks++;
            if (bus.env_out !== e_out || bus.env_state !== e_st || bus.env_active !== e_act)
                $display("FAIL random cyc%0d: out=%h/%h state=%0d/%0d active=%0b/%0b", i,
                         bus.env_out, e_out, bus.env_state, e_st, bus.env_active, e_act);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.gate = 1'b0;
        set_rates('0, '0, '0, '0);
        test_reset();
        test_full_cycle();
        test_retrigger();
        test_rise_on_tick();
        test_enable_freeze();
        test_release_floor();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
